// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Groups the byte-stream handshake and the core-side instruction-memory
//   write / reset / status signals of the program loader.
//   Parameter: ADDR_W - instruction-memory word-address width.
//   Signals:
//     byte_valid, byte_data[7:0]  byte stream from the source
//     byte_ready                  loader accepts a byte this cycle
//     WD[31:0], WA[ADDR_W-1:0]    instruction word and its word address
//     WE                          one-cycle write strobe for WD/WA
//     core_rst                    active-low reset to the core
//     ControlSignal               core completion flag
//     busy, err                   loader status
//   Modports: master = the loader, slave = source/core side.
`timescale 1ns/1ps
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic [31:0]       WD;
  logic [ADDR_W-1:0] WA;
  logic              WE;
  logic              core_rst;
  logic              ControlSignal;
  logic              busy;
  logic              err;

  modport master (
    input  byte_valid, byte_data, ControlSignal,
    output byte_ready, WD, WA, WE, core_rst, busy, err
  );

  modport slave (
    output byte_valid, byte_data, ControlSignal,
    input  byte_ready, WD, WA, WE, core_rst, busy, err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader
//   Receives a byte stream (16-bit little-endian word count N, then N
//   little-endian 32-bit words), writes each word into the core's
//   instruction memory while holding the core in reset, then releases the
//   core. A ControlSignal pulse from the running core re-arms the loader.
//   Parameter: ADDR_W - word-address width (max program 2**ADDR_W words,
//              ADDR_W must be at most 15 so the index fits the 16-bit count).
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-low reset
//     bus  - prog_loader_if master modport (stream, write path, status)
`timescale 1ns/1ps
module prog_loader #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.master bus
);

  typedef enum logic [1:0] {
    HDR_LO = 2'd0,
    HDR_HI = 2'd1,
    LOAD   = 2'd2,
    RUN    = 2'd3
  } loaderState_t;

  // Largest legal word count, one bit wider than the header count so that
  // 2**ADDR_W itself is representable.
  localparam logic [16:0] MaxWords = 17'(64'd1 << ADDR_W);

  loaderState_t      state;
  loaderState_t      nextState;

  logic              byteReady;
  logic              coreRst;
  logic              busyR;
  logic              errR;
  logic              weR;
  logic [31:0]       wdR;
  logic [ADDR_W-1:0] waR;

  logic              byteReadyNext;
  logic              coreRstNext;
  logic              busyNext;

  logic [7:0]        countLo;
  logic [15:0]       lastIdx;
  logic [ADDR_W:0]   wordIdx;
  logic [1:0]        lane;
  logic [23:0]       wordBuf;

  logic              accept;
  logic [15:0]       hdrCount;
  logic              hdrBad;
  logic              lastByte;

  assign accept   = bus.byte_valid & byteReady;
  assign hdrCount = {bus.byte_data, countLo};
  assign hdrBad   = (hdrCount == 16'd0) || ({1'b0, hdrCount} > MaxWords);
  // The final byte of the program is the lane-3 byte of word N-1.
  assign lastByte = (lane == 2'd3) && (16'(wordIdx) == lastIdx);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HDR_LO;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: header bytes, payload bytes, then wait for the core.
  always_comb begin
    nextState = state;
    case (state)
      HDR_LO: if (accept) nextState = HDR_HI;
      HDR_HI: if (accept) nextState = hdrBad ? HDR_LO : LOAD;
      LOAD:   if (accept && lastByte) nextState = RUN;
      RUN:    if (bus.ControlSignal) nextState = HDR_LO;
      default: nextState = HDR_LO;
    endcase
  end

  // Output decode from the upcoming state, so the registered outputs change
  // on the same edge as the state they describe. Dropping byte_ready on the
  // edge into RUN guarantees nothing is consumed after the last byte.
  always_comb begin
    byteReadyNext = (nextState != RUN);
    coreRstNext   = (nextState == RUN);
    busyNext      = (nextState == HDR_HI) || (nextState == LOAD);
  end

  // Registered control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byteReady <= 1'b0;
      coreRst   <= 1'b0;
      busyR     <= 1'b0;
    end else begin
      byteReady <= byteReadyNext;
      coreRst   <= coreRstNext;
      busyR     <= busyNext;
    end
  end

  // Datapath: header capture, byte-lane assembly and the write strobe.
  // Lanes 0..2 collect in wordBuf; the lane-3 byte completes the word
  // straight into WD so the strobe appears one cycle after acceptance and
  // WD otherwise holds the last written word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countLo <= '0;
      lastIdx <= '0;
      wordIdx <= '0;
      lane    <= '0;
      wordBuf <= '0;
      wdR     <= '0;
      waR     <= '0;
      weR     <= 1'b0;
      errR    <= 1'b0;
    end else begin
      weR <= 1'b0;
      if (accept) begin
        case (state)
          HDR_LO: begin
            countLo <= bus.byte_data;
            errR    <= 1'b0;
          end
          HDR_HI: begin
            if (hdrBad) begin
              errR <= 1'b1;
            end else begin
              lastIdx <= hdrCount - 16'd1;
              wordIdx <= '0;
              lane    <= '0;
            end
          end
          LOAD: begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: wordBuf[7:0]   <= bus.byte_data;
              2'd1: wordBuf[15:8]  <= bus.byte_data;
              2'd2: wordBuf[23:16] <= bus.byte_data;
              default: begin
                wdR     <= {bus.byte_data, wordBuf};
                waR     <= wordIdx[ADDR_W-1:0];
                weR     <= 1'b1;
                wordIdx <= wordIdx + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_ready = byteReady;
  assign bus.core_rst   = coreRst;
  assign bus.busy       = busyR;
  assign bus.err        = errR;
  assign bus.WE         = weR;
  assign bus.WD         = wdR;
  assign bus.WA         = waR;

endmodule
